// File: rtl/exec_pkg.sv
// Shared types for the execute stage: ARM data-processing opcodes, NZCV flag
// layout, FSM state encoding and the flag-update masks for each op class.
package exec_pkg;

  typedef enum logic [3:0] {
    OP_AND = 4'b0000,
    OP_EOR = 4'b0001,
    OP_SUB = 4'b0010,
    OP_RSB = 4'b0011,
    OP_ADD = 4'b0100,
    OP_ADC = 4'b0101,
    OP_SBC = 4'b0110,
    OP_TST = 4'b1000,
    OP_TEQ = 4'b1001,
    OP_CMP = 4'b1010,
    OP_CMN = 4'b1011,
    OP_ORR = 4'b1100,
    OP_MOV = 4'b1101,
    OP_BIC = 4'b1110,
    OP_MVN = 4'b1111
  } alu_op_t;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } nzcv_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } exec_state_t;

  localparam logic [3:0] MASK_ARITH = 4'b1111;
  localparam logic [3:0] MASK_LOGIC = 4'b1110;
  localparam logic [3:0] MASK_MUL   = 4'b1100;

endpackage

// File: rtl/mul_iter.sv
// Iterative shift-add multiplier: one partial product per cycle for WIDTH
// cycles, keeping only the low WIDTH bits. done_o flags the final iteration;
// product_o is the finished product during that cycle, result_o holds it after.
module mul_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             done_o,
  output logic [WIDTH-1:0] product_o,
  output logic [WIDTH-1:0] result_o
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic [WIDTH-1:0] acc_add;

  // Next-state: load operands on start, otherwise add one partial product per cycle
  always_comb begin
    acc_add  = acc_q + (mplier_q[0] ? mcand_q : '0);
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    if (start_i) begin
      acc_d    = '0;
      mcand_d  = a_i;
      mplier_d = b_i;
      cnt_d    = '0;
      busy_d   = 1'b1;
    end else if (busy_q) begin
      acc_d    = acc_add;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CW'(1);
      if (cnt_q == LAST) begin
        busy_d = 1'b0;
      end
    end
  end

  // Multiplier state registers; reset drops any in-flight product
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
    end
  end

  assign done_o    = busy_q && (cnt_q == LAST);
  assign product_o = acc_add;
  assign result_o  = acc_q;

endmodule

// File: rtl/execute_stage.sv
// Registered ARM execute stage behind the operand-2 shifter. Single-cycle ALU
// ops with NZCV generation, valid/ready on both sides.
// Build option: define MUL_EN to build the iterative WIDTH-cycle multiplier and
// the BUSY/DONE states; without it an accepted MUL completes in one cycle as
// undefined (result 0, mask 0000, out_undef=1).
module execute_stage
  import exec_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_shift_c,
  input  logic [3:0]       in_op,
  input  logic             in_mul,
  input  logic [3:0]       in_flags,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [3:0]       out_flags,
  output logic [3:0]       out_flags_mask,
  output logic             out_undef
);

  exec_state_t      state_q, state_d;
  alu_op_t          op;
  logic             out_free;
  logic             accept;

  logic [WIDTH-1:0] add_x, add_y, log_res;
  logic             add_cin, is_arith, is_undef;
  logic [WIDTH:0]   add_sum;
  logic             add_v;
  logic [WIDTH-1:0] alu_res;
  nzcv_t            alu_flags;
  logic [3:0]       alu_mask;

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  nzcv_t            flags_q, flags_d;
  logic [3:0]       mask_q, mask_d;
  logic             undef_q, undef_d;

  assign op       = alu_op_t'(in_op);
  assign out_free = !valid_q || out_ready;
  assign in_ready = (state_q == ST_IDLE) && out_free;
  assign accept   = in_valid && in_ready;

  // Operand steering: every arithmetic op is one adder pass x + y + cin
  always_comb begin
    add_x    = in_a;
    add_y    = in_b;
    add_cin  = 1'b0;
    is_arith = 1'b0;
    is_undef = 1'b0;
    log_res  = '0;
    case (op)
      OP_SUB, OP_CMP: begin add_y = ~in_b; add_cin = 1'b1; is_arith = 1'b1; end
      OP_RSB:         begin add_x = ~in_a; add_cin = 1'b1; is_arith = 1'b1; end
      OP_ADD, OP_CMN: begin is_arith = 1'b1; end
      OP_ADC:         begin add_cin = in_flags[1]; is_arith = 1'b1; end
      OP_SBC:         begin add_y = ~in_b; add_cin = in_flags[1]; is_arith = 1'b1; end
      OP_AND, OP_TST: log_res = in_a & in_b;
      OP_EOR, OP_TEQ: log_res = in_a ^ in_b;
      OP_ORR:         log_res = in_a | in_b;
      OP_MOV:         log_res = in_b;
      OP_BIC:         log_res = in_a & ~in_b;
      OP_MVN:         log_res = ~in_b;
      default:        is_undef = 1'b1;
    endcase
  end

  assign add_sum = {1'b0, add_x} + {1'b0, add_y} + {{WIDTH{1'b0}}, add_cin};
  assign add_v   = (add_x[WIDTH-1] == add_y[WIDTH-1]) &&
                   (add_sum[WIDTH-1] != add_x[WIDTH-1]);

  // Result and flag selection; an undefined op passes the incoming flags through
  always_comb begin
    alu_res   = is_arith ? add_sum[WIDTH-1:0] : log_res;
    alu_flags = in_flags;
    alu_mask  = 4'b0000;
    if (!is_undef) begin
      alu_flags.n = alu_res[WIDTH-1];
      alu_flags.z = (alu_res == '0);
      if (is_arith) begin
        alu_flags.c = add_sum[WIDTH];
        alu_flags.v = add_v;
        alu_mask    = MASK_ARITH;
      end else begin
        alu_flags.c = in_shift_c;
        alu_mask    = MASK_LOGIC;
      end
    end
  end

`ifdef MUL_EN
  logic             mul_start;
  logic             mul_done;
  logic [WIDTH-1:0] mul_product, mul_result;
  logic [1:0]       mul_cv_q;

  mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk       (clk),
    .reset     (reset),
    .start_i   (mul_start),
    .a_i       (in_a),
    .b_i       (in_b),
    .done_o    (mul_done),
    .product_o (mul_product),
    .result_o  (mul_result)
  );

  // C and V are carried through a MUL unchanged, so capture them at accept
  always_ff @(posedge clk) begin
    if (mul_start) begin
      mul_cv_q <= in_flags[1:0];
    end
  end
`endif

  // FSM next state and output-register next value; drain clears valid unless refilled
  always_comb begin
    state_d  = state_q;
    valid_d  = valid_q && !out_ready;
    result_d = result_q;
    flags_d  = flags_q;
    mask_d   = mask_q;
    undef_d  = undef_q;
`ifdef MUL_EN
    mul_start = 1'b0;
`endif
    case (state_q)
`ifdef MUL_EN
      ST_BUSY: begin
        if (mul_done) begin
          if (out_free) begin
            valid_d  = 1'b1;
            result_d = mul_product;
            flags_d  = {mul_product[WIDTH-1], (mul_product == '0), mul_cv_q};
            mask_d   = MASK_MUL;
            undef_d  = 1'b0;
            state_d  = ST_IDLE;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        if (out_free) begin
          valid_d  = 1'b1;
          result_d = mul_result;
          flags_d  = {mul_result[WIDTH-1], (mul_result == '0), mul_cv_q};
          mask_d   = MASK_MUL;
          undef_d  = 1'b0;
          state_d  = ST_IDLE;
        end
      end
`endif
      default: begin
        if (accept) begin
          if (in_mul) begin
`ifdef MUL_EN
            mul_start = 1'b1;
            state_d   = ST_BUSY;
`else
            valid_d  = 1'b1;
            result_d = '0;
            flags_d  = in_flags;
            mask_d   = 4'b0000;
            undef_d  = 1'b1;
`endif
          end else begin
            valid_d  = 1'b1;
            result_d = alu_res;
            flags_d  = alu_flags;
            mask_d   = alu_mask;
            undef_d  = is_undef;
          end
        end
      end
    endcase
  end

  // State and output bundle registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      valid_q  <= 1'b0;
      result_q <= '0;
      flags_q  <= '0;
      mask_q   <= 4'b0000;
      undef_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      valid_q  <= valid_d;
      result_q <= result_d;
      flags_q  <= flags_d;
      mask_q   <= mask_d;
      undef_q  <= undef_d;
    end
  end

  assign out_valid      = valid_q;
  assign out_result     = result_q;
  assign out_flags      = flags_q;
  assign out_flags_mask = mask_q;
  assign out_undef      = undef_q;

endmodule
